// File: rtl/piso_async.sv
// piso_async: parallel-in serial-out shift register with async active-high reset.
// Takes a WIDTH-bit word on load && ready. The word then leaves one bit per clock
// on serial_out, qualified by serial_valid. last marks the final bit of the frame.
// A new word can be taken on the last-bit cycle, so frames can run back to back.
module piso_async #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             cnt_zero;
    logic             accept;

    assign cnt_zero = (cnt == '0);
    // ready is a decode of registered state, so accept has no comb path to outputs
    assign accept   = load && ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: leave SHIFT only at frame end without a reload
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SHIFT;
            SHIFT:   if (cnt_zero && !load) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        ready        = 1'b1;
        serial_valid = 1'b0;
        serial_out   = 1'b0;
        last         = 1'b0;
        if (state == SHIFT) begin
            serial_valid = 1'b1;
            serial_out   = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
            last         = cnt_zero;
            ready        = cnt_zero;
        end
    end

    // Datapath: load word, shift toward the output end, clear when the frame ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= parallel_in;
            cnt   <= CW'(WIDTH - 1);
        end else if (state == SHIFT) begin
            if (cnt_zero) begin
                shreg <= '0;
            end else begin
                if (MSB_FIRST != 0) shreg <= {shreg[WIDTH-2:0], 1'b0};
                else                shreg <= {1'b0, shreg[WIDTH-1:1]};
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule
